// File: rtl/pila_pkg.sv
// Shared types and constants for the return-stack controller (ctrl_pila).
// Build option: CTRL_PILA_RR_EN selects round-robin arbitration in arbitro2.
package pila_pkg;

  localparam int WIDTH_DEF = 10;
  localparam int DEPTH_DEF = 16;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    EJEC   = 2'd1,
    RESP   = 2'd2
  } estado_t;

endpackage

// File: rtl/ctrl_pila_arbitro2.sv
// arbitro2: 2-way arbiter for the return-stack controller.
// Build option: CTRL_PILA_RR_EN.
//   defined   -> round-robin; on a tie the requester not granted last wins.
//   undefined -> fixed priority, requester 1 (interrupt path) always wins.
// gnt is combinational; the caller only honours it while idle (acepta=1).
module arbitro2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       acepta,
  output logic [1:0] gnt
);

`ifdef CTRL_PILA_RR_EN
  logic ultimo;

  // Tie broken against the last winner; single requests pass straight through.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ultimo ? 2'b01 : 2'b10;
  end

  // Last-grant pointer, starts at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 ultimo <= 1'b1;
    else if (acepta && |req)    ultimo <= gnt[1];
  end
`else
  logic unused_arb;
  assign unused_arb = ^{clk, reset, acepta};

  // Fixed priority: requester 1 first.
  always_comb begin
    gnt = 2'b00;
    if (req[1])      gnt = 2'b10;
    else if (req[0]) gnt = 2'b01;
  end
`endif

endmodule

// File: rtl/ctrl_pila.sv
// ctrl_pila: arbiter/sequencer for the hardware return stack (pila + mempila).
// Two requesters share the stack; each granted operation runs REPOSO->EJEC->RESP.
// Build option: CTRL_PILA_RR_EN (round-robin arbitration, see arbitro2).
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   REPOSO | idle; arbitrate, latch winner, pre-load stack strobes
//   EJEC   | stack strobes high for one cycle; update cuenta, capture pop data
//   RESP   | one-cycle ack to the latched requester, rdato/rerr valid
module ctrl_pila
  import pila_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             op0,
  input  logic [WIDTH-1:0] dato0,
  output logic             ack0,
  input  logic             req1,
  input  logic             op1,
  input  logic [WIDTH-1:0] dato1,
  output logic             ack1,
  output logic [WIDTH-1:0] rdato,
  output logic             rerr,
  output logic             pila_push,
  output logic             pila_pop,
  output logic             pila_we,
  output logic [WIDTH-1:0] pila_entrada,
  input  logic [WIDTH-1:0] pila_salida,
  output logic             lleno,
  output logic             vacio,
  output logic [CW-1:0]    cuenta,
  output logic             error
);

  estado_t           estado;
  logic [1:0]        gnt;
  logic              id_q;
  logic              op_q;
  logic              op_w;
  logic [WIDTH-1:0]  dato_w;

  arbitro2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1, req0}),
    .acepta (estado == REPOSO),
    .gnt    (gnt)
  );

  assign op_w   = gnt[1] ? op1   : op0;
  assign dato_w = gnt[1] ? dato1 : dato0;
  assign lleno  = (cuenta == CW'(DEPTH));
  assign vacio  = (cuenta == '0);

  // Sequencer: strobes are decided at grant so they are registered for all of EJEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado       <= REPOSO;
      id_q         <= 1'b0;
      op_q         <= OP_POP;
      cuenta       <= '0;
      error        <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rerr         <= 1'b0;
      rdato        <= '0;
      pila_push    <= 1'b0;
      pila_pop     <= 1'b0;
      pila_we      <= 1'b0;
      pila_entrada <= '0;
    end else begin
      case (estado)
        REPOSO: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (|gnt) begin
            id_q   <= gnt[1];
            op_q   <= op_w;
            estado <= EJEC;
            if (op_w == OP_PUSH && !lleno) begin
              pila_push    <= 1'b1;
              pila_we      <= 1'b1;
              pila_entrada <= dato_w;
            end else if (op_w == OP_POP && !vacio) begin
              pila_pop <= 1'b1;
              pila_we  <= 1'b1;
            end
          end
        end
        EJEC: begin
          pila_push    <= 1'b0;
          pila_pop     <= 1'b0;
          pila_we      <= 1'b0;
          pila_entrada <= '0;
          rerr         <= 1'b0;
          if (op_q == OP_PUSH) begin
            if (!lleno) cuenta <= cuenta + 1'b1;
            else begin
              rerr  <= 1'b1;
              error <= 1'b1;
            end
          end else begin
            if (!vacio) begin
              cuenta <= cuenta - 1'b1;
              rdato  <= pila_salida;
            end else begin
              rerr  <= 1'b1;
              error <= 1'b1;
            end
          end
          ack0   <= ~id_q;
          ack1   <= id_q;
          estado <= RESP;
        end
        RESP: begin
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          estado <= REPOSO;
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_pila.sv
// Directed bench for ctrl_pila with a behavioural return-stack model.
module tb_ctrl_pila;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
  logic [W-1:0] dato0 = '0, dato1 = '0;
  logic         ack0, ack1, rerr, pila_push, pila_pop, pila_we, lleno, vacio, error;
  logic [W-1:0] rdato, pila_entrada, pila_salida;
  logic [4:0]   cuenta;

  int checks = 0;
  int failures = 0;

  ctrl_pila dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .dato0(dato0), .ack0(ack0),
    .req1(req1), .op1(op1), .dato1(dato1), .ack1(ack1),
    .rdato(rdato), .rerr(rerr),
    .pila_push(pila_push), .pila_pop(pila_pop), .pila_we(pila_we),
    .pila_entrada(pila_entrada), .pila_salida(pila_salida),
    .lleno(lleno), .vacio(vacio), .cuenta(cuenta), .error(error)
  );

  always #5 clk = ~clk;

  // stack model: salida shows the top entry
  logic [W-1:0] mem [0:15];
  logic [4:0]   sp;
  assign pila_salida = (sp == 0) ? '0 : mem[sp - 1];
  always @(posedge clk or negedge reset) begin
    if (!reset) sp <= '0;
    else if (pila_we && pila_push) begin mem[sp[3:0]] <= pila_entrada; sp <= sp + 1; end
    else if (pila_we && pila_pop)  sp <= sp - 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic         r_err, s_push, s_pop, s_we, s_both;
  logic [W-1:0] r_dato;
  int           lat;

  task automatic run_op(input int who, input logic op, input logic [W-1:0] d);
    bit got = 0;
    @(negedge clk);
    if (who == 0) begin req0 = 1; op0 = op; dato0 = d; end
    else          begin req1 = 1; op1 = op; dato1 = d; end
    s_push = 0; s_pop = 0; s_we = 0; s_both = 0; lat = 0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (pila_push) s_push = 1;
      if (pila_pop)  s_pop = 1;
      if (pila_we)   s_we = 1;
      if (pila_push && pila_pop) s_both = 1;
      if ((who == 0) ? ack0 : ack1) begin
        got = 1; lat = c; r_err = rerr; r_dato = rdato;
      end
    end
    if (!got) chk("ack_timeout", 0, 1);
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
  endtask

  int order[4];
  int n;

  initial begin
    // reset state
    #12;
    chk("rst_cuenta", cuenta, 0);
    chk("rst_vacio", vacio, 1);
    chk("rst_lleno", lleno, 0);
    chk("rst_error", error, 0);
    chk("rst_acks", {ack0, ack1, rerr}, 0);
    chk("rst_strobes", {pila_push, pila_pop, pila_we}, 0);
    chk("rst_rdato", rdato, 0);
    @(negedge clk); reset = 1;

    // push 0x155 from requester 0
    run_op(0, 1'b1, 10'h155);
    chk("t1_lat", lat, 2);
    chk("t1_strobes", {s_push, s_pop, s_we}, 3'b101);
    chk("t1_rerr", r_err, 0);
    chk("t1_cuenta", cuenta, 1);
    chk("t1_vacio", vacio, 0);

    // pop from requester 1
    run_op(1, 1'b0, 10'h0);
    chk("t2_strobes", {s_push, s_pop, s_we}, 3'b011);
    chk("t2_rdato", r_dato, 10'h155);
    chk("t2_rerr", r_err, 0);
    chk("t2_cuenta", cuenta, 0);
    chk("t2_vacio", vacio, 1);

    // pop when empty
    run_op(0, 1'b0, 10'h0);
    chk("t3_strobes", {s_push, s_pop, s_we}, 3'b000);
    chk("t3_rerr", r_err, 1);
    chk("t3_error", error, 1);
    chk("t3_cuenta", cuenta, 0);

    // fill, overflow, drain
    for (int i = 0; i < 16; i++) begin
      run_op(0, 1'b1, W'(i));
      chk("t4_push_rerr", r_err, 0);
    end
    chk("t4_lleno", lleno, 1);
    chk("t4_cuenta16", cuenta, 16);
    run_op(1, 1'b1, 10'h3ff);
    chk("t4_ovf_rerr", r_err, 1);
    chk("t4_ovf_strobes", {s_push, s_pop, s_we}, 3'b000);
    chk("t4_ovf_cuenta", cuenta, 16);
    for (int i = 15; i >= 0; i--) begin
      run_op(i % 2, 1'b0, 10'h0);
      chk("t4_pop_rdato", r_dato, i);
      chk("t4_pop_both", s_both, 0);
    end
    chk("t4_vacio", vacio, 1);
    chk("t4_error_sticky", error, 1);

    // reset pulse, then both requesters held with pushes
    @(negedge clk); reset = 0;
    @(negedge clk);
    chk("t5_error_clr", error, 0);
    reset = 1;
    @(negedge clk);
    req0 = 1; op0 = 1; dato0 = 10'h0aa;
    req1 = 1; op1 = 1; dato1 = 10'h0bb;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (ack0 && ack1) chk("t5_two_acks", 1, 0);
      if (ack0) begin order[n] = 0; n++; end
      else if (ack1) begin order[n] = 1; n++; end
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    chk("t5_ngrants", n, 4);
`ifdef CTRL_PILA_RR_EN
    chk("t5_g0", order[0], 0);
    chk("t5_g1", order[1], 1);
    chk("t5_g2", order[2], 0);
    chk("t5_g3", order[3], 1);
`else
    chk("t5_g0", order[0], 1);
    chk("t5_g1", order[1], 1);
    chk("t5_g2", order[2], 1);
    chk("t5_g3", order[3], 1);
`endif
    chk("t5_cuenta", cuenta, 4);

    // reset during EJEC of a push
    @(negedge clk);
    req0 = 1; op0 = 1; dato0 = 10'h2aa;
    @(posedge clk); #1;
    chk("t6_in_ejec", pila_push, 1);
    reset = 0;
    #1;
    chk("t6_strobes", {pila_push, pila_pop, pila_we}, 0);
    chk("t6_entrada", pila_entrada, 0);
    chk("t6_acks", {ack0, ack1, rerr}, 0);
    chk("t6_cuenta", cuenta, 0);
    chk("t6_rdato", rdato, 0);
    req0 = 0;
    @(negedge clk); @(negedge clk);
    reset = 1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack0 || ack1) n++;
    end
    chk("t6_no_ack", n, 0);
    chk("t6_cuenta_after", cuenta, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
